// File: rtl/timer_pkg.sv
// Shared register map, TCR/TSR layout and clock-select encodings
// for the parameterised APB timer.
package timer_pkg;

  localparam logic [7:0] A_TDR  = 8'h00;
  localparam logic [7:0] A_TCR  = 8'h01;
  localparam logic [7:0] A_TSR  = 8'h02;
  localparam logic [7:0] A_TIER = 8'h03;
  localparam logic [7:0] A_TCNT = 8'h04;

  localparam int TCR_LOAD = 7;
  localparam int TCR_DIR  = 5;
  localparam int TCR_EN   = 4;
  localparam int TCR_AR   = 3;
  localparam int TCR_CKS  = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  localparam logic [7:0] TCR_MASK =
    (8'd1 << TCR_LOAD) | (8'd1 << TCR_DIR) |
    (8'd1 << TCR_EN)   | (8'd1 << TCR_AR)  |
    (8'd3 << TCR_CKS);

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  typedef struct packed {
    logic load;
    logic rsv6;
    logic dir;
    logic en;
    logic ar;
    logic rsv2;
    cks_e cks;
  } tcr_t;

  typedef enum logic [2:0] {
    SEL_TDR,
    SEL_TCR,
    SEL_TSR,
    SEL_TIER,
    SEL_TCNT,
    SEL_NONE
  } sel_e;

  // Low divider bits that must all be set for a tick.
  function automatic logic [3:0] cks_mask(cks_e c);
    cks_mask = 4'b1111;
    unique case (c)
      CKS_DIV2:  cks_mask = 4'b0001;
      CKS_DIV4:  cks_mask = 4'b0011;
      CKS_DIV8:  cks_mask = 4'b0111;
      CKS_DIV16: cks_mask = 4'b1111;
      default:   cks_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 4-bit divider producing the counter tick
// at pclk/2, /4, /8 or /16.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       pclk,
  input  logic       preset,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [3:0] div;
  logic [3:0] mask;

  always_ff @(posedge pclk) begin
    if (preset || !en || load) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  assign mask = cks_mask(cks_e'(cks));
  assign tick = en & ~load & ((div & mask) == mask);

endmodule

// File: rtl/timer_param.sv
// APB timer: TDR/TCR/TSR/TIER/TCNT register file and an
// up/down counter with overflow/underflow flags and auto-reload.
module timer_param
  import timer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [WIDTH-1:0]  pwdata,
  output logic [WIDTH-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              tmr_ovf,
  output logic              tmr_udf,
  output logic              irq
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] tdr;
  tcr_t             tcr;
  logic [1:0]       tsr;
  logic [1:0]       tier;
  logic [WIDTH-1:0] cnt;

  sel_e             sel;
  logic             wr;
  logic             tick;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_set;
  logic             udf_set;
  logic [1:0]       w1c;

  logic [WIDTH-1:0] tcr_rd;
  logic [WIDTH-1:0] tsr_rd;
  logic [WIDTH-1:0] tier_rd;

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      (paddr == ADDR_W'(A_TDR)):  sel = SEL_TDR;
      (paddr == ADDR_W'(A_TCR)):  sel = SEL_TCR;
      (paddr == ADDR_W'(A_TSR)):  sel = SEL_TSR;
      (paddr == ADDR_W'(A_TIER)): sel = SEL_TIER;
      (paddr == ADDR_W'(A_TCNT)): sel = SEL_TCNT;
      default:                    sel = SEL_NONE;
    endcase
  end

  assign wr      = psel & penable & pwrite;
  assign pready  = 1'b1;
  assign pslverr = psel & penable & (sel == SEL_NONE);

  timer_prescaler u_pre (
    .pclk   (pclk),
    .preset (preset),
    .en     (tcr.en),
    .load   (tcr.load),
    .cks    (tcr.cks),
    .tick   (tick)
  );

  // Load beats tick; loads never raise a flag.
  always_comb begin
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (tcr.load) begin
      cnt_nxt = tdr;
    end else if (tick) begin
      if (!tcr.dir) begin
        if (cnt == CNT_MAX) begin
          ovf_set = 1'b1;
          cnt_nxt = tcr.ar ? tdr : '0;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (cnt == '0) begin
          udf_set = 1'b1;
          cnt_nxt = tcr.ar ? tdr : CNT_MAX;
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  assign w1c = (wr && sel == SEL_TSR) ? pwdata[1:0] : 2'b00;

  always_ff @(posedge pclk) begin
    if (preset) begin
      tdr  <= '0;
      tcr  <= '0;
      tsr  <= '0;
      tier <= '0;
      cnt  <= '0;
    end else begin
      if (wr && sel == SEL_TDR) begin
        tdr <= pwdata;
      end
      if (wr && sel == SEL_TCR) begin
        tcr <= tcr_t'(pwdata[7:0] & TCR_MASK);
      end
      if (wr && sel == SEL_TIER) begin
        tier <= pwdata[1:0];
      end
      // A flag event in the same cycle outranks the clear.
      tsr <= (tsr & ~w1c) | {udf_set, ovf_set};
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    tcr_rd       = '0;
    tcr_rd[7:0]  = tcr;
    tsr_rd       = '0;
    tsr_rd[1:0]  = tsr;
    tier_rd      = '0;
    tier_rd[1:0] = tier;
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      unique case (sel)
        SEL_TDR:  prdata = tdr;
        SEL_TCR:  prdata = tcr_rd;
        SEL_TSR:  prdata = tsr_rd;
        SEL_TIER: prdata = tier_rd;
        SEL_TCNT: prdata = cnt;
        default:  prdata = '0;
      endcase
    end
  end

  assign tmr_ovf = tsr[TSR_OVF];
  assign tmr_udf = tsr[TSR_UDF];
  assign irq     = |(tsr & tier);

endmodule

// File: tb/tb_timer_param.sv
// Randomised and directed bench for timer_param against a
// cycle-level behavioural model of the register map and counter.
module tb_timer_param;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       tmr_ovf;
  logic       tmr_udf;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  timer_param #(.WIDTH(8), .ADDR_W(8)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  // Model state
  logic [7:0] m_tdr;
  logic [7:0] m_tcr;
  logic [1:0] m_tsr;
  logic [1:0] m_tier;
  logic [7:0] m_cnt;
  int         m_div;
  bit         chk_on = 1'b0;

  function automatic bit mapped(logic [7:0] a);
    return a <= 8'h04;
  endfunction

  function automatic logic [7:0] m_read(logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return m_tcr;
      8'h02:   return {6'b0, m_tsr};
      8'h03:   return {6'b0, m_tier};
      8'h04:   return m_cnt;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge pclk) begin : model
    bit         ld, en, dn, ar, tk, of, uf, wa;
    int         per;
    logic [7:0] nc;
    logic [1:0] ns;
    if (preset) begin
      m_tdr  <= 8'h00;
      m_tcr  <= 8'h00;
      m_tsr  <= 2'b00;
      m_tier <= 2'b00;
      m_cnt  <= 8'h00;
      m_div  <= 0;
      chk_on <= 1'b1;
    end else begin
      ld  = m_tcr[7];
      dn  = m_tcr[5];
      en  = m_tcr[4];
      ar  = m_tcr[3];
      per = 1 << (int'(m_tcr[1:0]) + 1);
      tk  = en && !ld && ((m_div % per) == per - 1);
      of  = 1'b0;
      uf  = 1'b0;
      nc  = m_cnt;
      if (ld) nc = m_tdr;
      else if (tk && !dn) begin
        if (m_cnt == 8'd255) begin
          of = 1'b1;
          nc = ar ? m_tdr : 8'd0;
        end else nc = m_cnt + 8'd1;
      end else if (tk && dn) begin
        if (m_cnt == 8'd0) begin
          uf = 1'b1;
          nc = ar ? m_tdr : 8'd255;
        end else nc = m_cnt - 8'd1;
      end
      wa = psel && penable && pwrite && mapped(paddr);
      ns = m_tsr | {uf, of};
      if (wa && paddr == 8'h02) ns = (m_tsr & ~pwdata[1:0]) | {uf, of};
      m_tsr <= ns;
      m_cnt <= nc;
      m_div <= (!en || ld) ? 0 : (m_div + 1) % 16;
      if (wa && paddr == 8'h00) m_tdr  <= pwdata;
      if (wa && paddr == 8'h01) m_tcr  <= pwdata & 8'hBB;
      if (wa && paddr == 8'h03) m_tier <= pwdata[1:0];
    end
  end

  always @(negedge pclk) begin
    if (chk_on) begin
      chk("prdata", prdata,
          (psel && !pwrite) ? m_read(paddr) : 8'h00);
      chk("pslverr", pslverr, psel && penable && !mapped(paddr));
      chk("pready", pready, 1'b1);
      chk("tmr_ovf", tmr_ovf, m_tsr[0]);
      chk("tmr_udf", tmr_udf, m_tsr[1]);
      chk("irq", irq, |(m_tsr & m_tier));
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = a; pwdata = d;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(logic [7:0] a, output logic [7:0] v);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk); v = prdata;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    logic [7:0] v;
    for (int a = 0; a < 5; a++) begin
      rd(8'(a), v);
      chk($sformatf("%s_reg%0d", tag, a), v, 8'h00);
    end
    chk({tag, "_irq"}, irq, 1'b0);
    chk({tag, "_ovf"}, tmr_ovf, 1'b0);
    chk({tag, "_udf"}, tmr_udf, 1'b0);
  endtask

  initial begin
    logic [7:0] v;
    int         r;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    chk_all_zero("rst");

    // No fake overflow from successive loads
    wr(8'h00, 8'hFF); wr(8'h01, 8'h80);
    wr(8'h00, 8'h00); wr(8'h01, 8'h80);
    idle(2);
    rd(8'h02, v); chk("fake_ovf_a", v, 8'h00);
    wr(8'h00, 8'hFF); wr(8'h01, 8'h80);
    wr(8'h00, 8'h00); wr(8'h01, 8'h90);
    idle(2);
    rd(8'h02, v); chk("fake_ovf_b", v, 8'h00);

    // Up overflow with interrupt
    do_reset();
    wr(8'h00, 8'hFE); wr(8'h01, 8'h80);
    wr(8'h03, 8'h01); wr(8'h01, 8'h10);
    idle(4);
    rd(8'h04, v); chk("up_tcnt", v, 8'h00);
    chk("up_irq", irq, 1'b1);
    rd(8'h02, v); chk("up_tsr", v, 8'h01);

    // Down underflow at /4
    do_reset();
    wr(8'h00, 8'h01); wr(8'h01, 8'hA0); wr(8'h01, 8'h31);
    idle(4);
    rd(8'h04, v); chk("dn_tcnt0", v, 8'h00);
    idle(2);
    rd(8'h04, v); chk("dn_tcntff", v, 8'hFF);
    rd(8'h02, v); chk("dn_tsr", v, 8'h02);

    // Auto-reload
    do_reset();
    wr(8'h00, 8'hFD); wr(8'h01, 8'h80); wr(8'h01, 8'h18);
    idle(6);
    rd(8'h04, v); chk("ar_tcnt", v, 8'hFD);
    rd(8'h02, v); chk("ar_tsr", v, 8'h01);

    // Clear landing on the overflow edge
    do_reset();
    wr(8'h00, 8'hFE); wr(8'h01, 8'h80); wr(8'h01, 8'h10);
    idle(2);
    wr(8'h02, 8'h01);
    rd(8'h02, v); chk("w1c_race", v, 8'h01);
    wr(8'h02, 8'h01);
    rd(8'h02, v); chk("w1c_clear", v, 8'h00);

    // Reset mid-count and unmapped access
    do_reset();
    wr(8'h00, 8'h42); wr(8'h01, 8'h80); wr(8'h03, 8'h03);
    rd(8'h04, v); chk("pre_rst_tcnt", v, 8'h42);
    do_reset();
    chk_all_zero("midrst");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h07;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    chk("err_pslverr", pslverr, 1'b1);
    chk("err_prdata", prdata, 8'h00);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;

    // Randomised scenarios near the wrap points
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      r = $urandom_range(0, 7);
      wr(8'h00, (r < 4) ? 8'(r) : (8'hF8 | 8'(r)));
      wr(8'h01, 8'h80 | (8'($urandom) & 8'h20));
      if ($urandom_range(0, 1) == 1) wr(8'h03, 8'($urandom));
      wr(8'h01, (8'($urandom) & 8'h7F) | 8'h10);
      for (int j = 0; j < int'($urandom_range(5, 40)); j++) begin
        r = $urandom_range(0, 99);
        if (r < 70) idle(1);
        else if (r < 80) rd(8'($urandom_range(0, 7)), v);
        else if (r < 90) wr(8'h02, 8'($urandom));
        else if (r < 95) wr(8'h01, (8'($urandom) & 8'h7F) | 8'h10);
        else wr(8'($urandom_range(5, 255)), 8'($urandom));
      end
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
